// File: rtl/g15_typeout_pkg.sv
// rtl/g15_typeout_pkg.sv - shared types and constants for the io_typeout typewriter sink
// Contents:
//   typeout_state_t   FSM state enum (IDLE, EMIT, EMIT_LF, DWELL)
//   CTL_*             OB control codes, meaning of {OB3,OB2,OB1} when OB5=0
//   ASC_*             ASCII bytes produced by the decoder
//   ob_is_printing()  true when a 5-bit OB code produces a host byte
package g15_typeout_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EMIT    = 2'd1,
        ST_EMIT_LF = 2'd2,
        ST_DWELL   = 2'd3
    } typeout_state_t;

    localparam logic [2:0] CTL_SPACE  = 3'b000;
    localparam logic [2:0] CTL_MINUS  = 3'b001;
    localparam logic [2:0] CTL_CR     = 3'b010;
    localparam logic [2:0] CTL_TAB    = 3'b011;
    localparam logic [2:0] CTL_STOP   = 3'b100;
    localparam logic [2:0] CTL_RELOAD = 3'b101;
    localparam logic [2:0] CTL_WAIT   = 3'b110;

    localparam logic [7:0] ASC_CR    = 8'h0D;
    localparam logic [7:0] ASC_LF    = 8'h0A;
    localparam logic [7:0] ASC_TAB   = 8'h09;
    localparam logic [7:0] ASC_MINUS = 8'h2D;
    localparam logic [7:0] ASC_SPACE = 8'h20;

    // Digits always print; control codes print only in the lower half
    // (OB3=0). STOP, RELOAD and both WAIT codes have OB3=1.
    function automatic logic ob_is_printing(input logic [4:0] code);
        return code[4] | ~code[2];
    endfunction

endpackage

// File: rtl/io_typeout_if.sv
// rtl/io_typeout_if.sv - host byte stream interface for io_typeout
// Signals:
//   tx_data   8  ASCII byte to host
//   tx_valid  1  tx_data is valid
//   tx_ready  1  host accepts when tx_valid & tx_ready
// Modports: master (typewriter sink side), slave (host side)
interface io_typeout_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/ob_to_ascii.sv
// rtl/ob_to_ascii.sv - combinational OB character code to ASCII decoder
// Ports:
//   code      in   5  OB5..OB1 (code[4] = OB5)
//   ascii     out  8  decoded byte (8'h00 for non-printing codes)
//   printing  out  1  code produces a host byte
//   is_cr     out  1  code is the carriage-return control
module ob_to_ascii
    import g15_typeout_pkg::*;
(
    input  logic [4:0] code,
    output logic [7:0] ascii,
    output logic       printing,
    output logic       is_cr
);

    always_comb begin
        ascii    = 8'h00;
        is_cr    = 1'b0;
        printing = ob_is_printing(code);
        if (code[4]) begin
            // 0-9 -> '0'-'9'; 10-15 -> 'u'-'z' ('u' = 8'h75 = 8'h6B + 10)
            if (code[3:0] < 4'd10) begin
                ascii = 8'h30 + {4'h0, code[3:0]};
            end else begin
                ascii = 8'h6B + {4'h0, code[3:0]};
            end
        end else begin
            // OB4 does not take part in control decoding
            case (code[2:0])
                CTL_SPACE:  ascii = ASC_SPACE;
                CTL_MINUS:  ascii = ASC_MINUS;
                CTL_CR: begin
                    ascii = ASC_CR;
                    is_cr = 1'b1;
                end
                CTL_TAB:    ascii = ASC_TAB;
                CTL_STOP,
                CTL_RELOAD,
                CTL_WAIT:   ascii = 8'h00;
                default:    ascii = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/io_typeout.sv
// rtl/io_typeout.sv - slow-out typewriter sink: OB character to ASCII host byte with HC pacing
// Parameters:
//   CHAR_CYCLES  dwell cycles after each character before HC rises (1..255)
// Optional feature macro: IO_TYPEOUT_CRLF_EN (CR is followed by an LF byte)
// Ports:
//   CLOCK      in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   TYPE       in   typewriter selected; TYPE_STB ignored while low
//   TYPE_STB   in   one-cycle request to type OB1..OB5
//   OB1..OB5   in   output character buffer bits (OB5 = MSB)
//   tx         io   host byte stream (master modport)
//   HC         out  idle and ready for the next character (registered)
//   OVR        out  sticky: strobe arrived while busy
module io_typeout
    import g15_typeout_pkg::*;
#(
    parameter int CHAR_CYCLES = 4
) (
    input  logic           CLOCK,
    input  logic           rst,
    input  logic           TYPE,
    input  logic           TYPE_STB,
    input  logic           OB1,
    input  logic           OB2,
    input  logic           OB3,
    input  logic           OB4,
    input  logic           OB5,
    io_typeout_if.master   tx,
    output logic           HC,
    output logic           OVR
);

    localparam int CW = $clog2(CHAR_CYCLES + 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(CHAR_CYCLES);
    localparam logic [CW-1:0] DWELL_LAST = CW'(1);

    typeout_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [4:0]     code_q, code_d;
    logic           ovr_d;

    logic [4:0]     ob_in;
    logic           strobe;
    logic [7:0]     dec_ascii;
    logic           dec_printing;
    logic           dec_is_cr;

    assign ob_in  = {OB5, OB4, OB3, OB2, OB1};
    assign strobe = TYPE & TYPE_STB;

    ob_to_ascii u_dec (
        .code     (code_q),
        .ascii    (dec_ascii),
        .printing (dec_printing),
        .is_cr    (dec_is_cr)
    );

`ifndef IO_TYPEOUT_CRLF_EN
    logic unused_is_cr;
    assign unused_is_cr = dec_is_cr;
`endif

    // The latched code was accepted as printing in IDLE, so the decoder's own
    // printing flag is only a consistency signal here.
    logic unused_printing;
    assign unused_printing = dec_printing;

    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            HC      <= 1'b1;
            OVR     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            // HC follows the state register exactly, without a decode glitch
            HC      <= (state_d == ST_IDLE);
            OVR     <= ovr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        ovr_d       = OVR;
        tx.tx_valid = 1'b0;
        tx.tx_data  = 8'h00;

        // Any strobe outside IDLE is dropped, including the DWELL exit cycle
        if (strobe && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (strobe) begin
                    code_d = ob_in;
                    if (ob_is_printing(ob_in)) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_DWELL;
                        cnt_d   = DWELL_LOAD;
                    end
                end
            end
            ST_EMIT: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = dec_ascii;
                if (tx.tx_ready) begin
                    state_d = ST_DWELL;
                    cnt_d   = DWELL_LOAD;
`ifdef IO_TYPEOUT_CRLF_EN
                    if (dec_is_cr) begin
                        state_d = ST_EMIT_LF;
                        cnt_d   = cnt_q;
                    end
`endif
                end
            end
            ST_EMIT_LF: begin
                tx.tx_valid = 1'b1;
                tx.tx_data  = ASC_LF;
                if (tx.tx_ready) begin
                    state_d = ST_DWELL;
                    cnt_d   = DWELL_LOAD;
                end
            end
            ST_DWELL: begin
                cnt_d = cnt_q - DWELL_LAST;
                if (cnt_q <= DWELL_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_io_typeout.sv
// tb/tb_io_typeout.sv - self-checking bench for io_typeout (table vectors, random, corner sequences)
module tb_io_typeout;

    localparam int CHAR = 4;
`ifdef IO_TYPEOUT_CRLF_EN
    localparam bit CRLF = 1'b1;
`else
    localparam bit CRLF = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       type_sel;
    logic       type_stb;
    logic [4:0] ob;
    logic       hc;
    logic       ovr;

    int checks = 0;
    int errors = 0;

    io_typeout_if txi ();

    io_typeout #(.CHAR_CYCLES(CHAR)) dut (
        .CLOCK    (clk),
        .rst      (rst),
        .TYPE     (type_sel),
        .TYPE_STB (type_stb),
        .OB1      (ob[0]),
        .OB2      (ob[1]),
        .OB3      (ob[2]),
        .OB4      (ob[3]),
        .OB5      (ob[4]),
        .tx       (txi),
        .HC       (hc),
        .OVR      (ovr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] code;
        logic [7:0] exp_byte;
        bit         exp_prt;
        int         stall;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %h required %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode straight from the character table
    function automatic void model_ascii(input logic [4:0] code, output logic [7:0] b, output bit p);
        string digits;
        digits = "0123456789uvwxyz";
        b = 8'h00;
        p = 1'b1;
        if (code[4]) begin
            b = digits[int'(code[3:0])];
        end else begin
            case (code[2:0])
                3'd0: b = " ";
                3'd1: b = "-";
                3'd2: b = 8'h0D;
                3'd3: b = 8'h09;
                default: p = 1'b0;
            endcase
        end
    endfunction

    task automatic wait_idle();
        int n;
        n = 0;
        while (hc !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", hc, 1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One character from strobe (cycle 0) through HC return:
    // HC must rise CHAR+1 cycles after the last handshake (or the strobe, if non-printing).
    task automatic do_char(input logic [4:0] code, input logic [7:0] exp, input bit prt, input int stall);
        int  cyc;
        int  hs;
        bit  lf;
        lf = CRLF && prt && (exp == 8'h0D);
        wait_idle();
        ob           = code;
        type_sel     = 1'b1;
        type_stb     = 1'b1;
        txi.tx_ready = (stall == 0);
        @(negedge clk);
        type_stb = 1'b0;
        cyc = 1;
        hs  = 0;
        if (prt) begin
            for (int s = 0; s < stall; s++) begin
                chk("stall_valid", txi.tx_valid, 1'b1);
                chk("stall_data", txi.tx_data, exp);
                chk("stall_hc", hc, 1'b0);
                @(negedge clk);
                cyc++;
            end
            txi.tx_ready = 1'b1;
            chk("byte_valid", txi.tx_valid, 1'b1);
            chk("byte_data", txi.tx_data, exp);
            hs = cyc;
            @(negedge clk);
            cyc++;
            if (lf) begin
                chk("lf_valid", txi.tx_valid, 1'b1);
                chk("lf_data", txi.tx_data, 8'h0A);
                hs = cyc;
                @(negedge clk);
                cyc++;
            end
        end
        while (cyc < hs + CHAR + 1) begin
            chk("dwell_hc", hc, 1'b0);
            chk("dwell_valid", txi.tx_valid, 1'b0);
            @(negedge clk);
            cyc++;
        end
        chk("hc_return", hc, 1'b1);
    endtask

    initial begin
        logic [7:0] mb;
        bit         mp;
        logic [4:0] rc;

        rst          = 1'b1;
        type_sel     = 1'b1;
        type_stb     = 1'b0;
        ob           = 5'b0;
        txi.tx_ready = 1'b1;

        vt[0]  = '{5'b10111, 8'h37, 1'b1, 0};
        vt[1]  = '{5'b11100, 8'h77, 1'b1, 0};
        vt[2]  = '{5'b00001, 8'h2D, 1'b1, 0};
        vt[3]  = '{5'b00100, 8'h00, 1'b0, 0};
        vt[4]  = '{5'b11001, 8'h39, 1'b1, 10};
        vt[5]  = '{5'b00010, 8'h0D, 1'b1, 0};
        vt[6]  = '{5'b01011, 8'h09, 1'b1, 0};
        vt[7]  = '{5'b11111, 8'h7A, 1'b1, 2};
        vt[8]  = '{5'b10000, 8'h30, 1'b1, 0};
        vt[9]  = '{5'b01000, 8'h20, 1'b1, 0};
        vt[10] = '{5'b00111, 8'h00, 1'b0, 0};
        vt[11] = '{5'b11010, 8'h75, 1'b1, 1};

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_hc", hc, 1'b1);
        chk("rst_valid", txi.tx_valid, 1'b0);
        chk("rst_ovr", ovr, 1'b0);
        chk("rst_data", txi.tx_data, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_hc", hc, 1'b1);
        chk("idle_valid", txi.tx_valid, 1'b0);

        for (int i = 0; i < 12; i++) begin
            do_char(vt[i].code, vt[i].exp_byte, vt[i].exp_prt, vt[i].stall);
        end

        // Reset mid-EMIT aborts immediately
        wait_idle();
        ob           = 5'b10111;
        type_stb     = 1'b1;
        txi.tx_ready = 1'b0;
        @(negedge clk);
        type_stb = 1'b0;
        chk("pre_abort_valid", txi.tx_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_valid", txi.tx_valid, 1'b0);
        chk("abort_hc", hc, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        txi.tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("abort_no_replay", txi.tx_valid, 1'b0);
        chk("abort_hc_after", hc, 1'b1);

        // Strobe while busy: OVR sets, byte unchanged, OVR sticky
        txi.tx_ready = 1'b0;
        ob           = 5'b10011;
        type_stb     = 1'b1;
        @(negedge clk);
        type_stb = 1'b0;
        chk("ovr_first_data", txi.tx_data, 8'h33);
        chk("ovr_clear_before", ovr, 1'b0);
        @(negedge clk);
        ob       = 5'b11111;
        type_stb = 1'b1;
        @(negedge clk);
        type_stb = 1'b0;
        chk("ovr_set", ovr, 1'b1);
        chk("ovr_data_kept", txi.tx_data, 8'h33);
        chk("ovr_valid_kept", txi.tx_valid, 1'b1);
        txi.tx_ready = 1'b1;
        @(negedge clk);
        wait_idle();
        chk("ovr_sticky", ovr, 1'b1);

        // TYPE=0 strobe does nothing
        type_sel = 1'b0;
        type_stb = 1'b1;
        @(negedge clk);
        type_stb = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("type0_valid", txi.tx_valid, 1'b0);
            chk("type0_hc", hc, 1'b1);
            @(negedge clk);
        end
        type_sel = 1'b1;

        // TYPE=0 strobe while busy leaves OVR clear
        do_reset();
        ob       = 5'b00100;
        type_stb = 1'b1;
        @(negedge clk);
        type_sel = 1'b0;
        ob       = 5'b10001;
        @(negedge clk);
        type_stb = 1'b0;
        type_sel = 1'b1;
        chk("type0_busy_ovr", ovr, 1'b0);
        wait_idle();

        // Strobe on the DWELL exit cycle is dropped and sets OVR
        ob           = 5'b10001;
        txi.tx_ready = 1'b1;
        type_stb     = 1'b1;
        @(negedge clk);
        type_stb = 1'b0;
        repeat (4) @(negedge clk);
        chk("exit_hc_low", hc, 1'b0);
        chk("exit_ovr_before", ovr, 1'b0);
        ob       = 5'b10010;
        type_stb = 1'b1;
        @(negedge clk);
        type_stb = 1'b0;
        chk("exit_ovr", ovr, 1'b1);
        chk("exit_hc", hc, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("exit_no_byte", txi.tx_valid, 1'b0);
            @(negedge clk);
        end

        // Random characters against the reference decode
        do_reset();
        for (int i = 0; i < 30; i++) begin
            rc = 5'($urandom_range(0, 31));
            model_ascii(rc, mb, mp);
            do_char(rc, mb, mp, int'($urandom_range(0, 3)));
        end
        chk("random_ovr", ovr, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual running required finished");
        $fatal(1, "timeout");
    end

endmodule
